// File: rtl/jesd204b_cgs_ctrl.sv
// JESD204B receiver code-group synchronization controller (CS_INIT/CS_CHECK/CS_DATA).
// Optional macro JESD_CGS_ERR_REPORT_EN adds 2-cycle SYNC~ error-report pulses in CS_DATA.
module jesd204b_cgs_ctrl #(
    parameter int K_CNT_MAX = 4,
    parameter int ERR_MAX   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dec_valid,
    input  logic [7:0] dec_data,
    input  logic       dec_is_k,
    input  logic       dec_disp_err,
    input  logic       dec_nit_err,
    input  logic       err_clr,
    output logic       sync_n,
    output logic [1:0] cgs_state,
    output logic       cgs_done,
    output logic [7:0] err_cnt
);

    localparam int KW = $clog2(K_CNT_MAX + 1);
    localparam int IW = $clog2(ERR_MAX + 1);
    localparam logic [KW-1:0] K_LIM = KW'(K_CNT_MAX);
    localparam logic [IW-1:0] I_LIM = IW'(ERR_MAX);

    typedef enum logic [1:0] {
        CS_INIT    = 2'b00,
        CS_CHECK   = 2'b01,
        CS_DATA    = 2'b10,
        CS_ILLEGAL = 2'b11
    } cgs_state_t;

    cgs_state_t    state_r, state_nxt_s;
    logic [KW-1:0] kcnt_r, kcnt_nxt_s, kcnt_inc_s;
    logic [IW-1:0] icnt_r, icnt_nxt_s, icnt_inc_s;
    logic [7:0]    err_cnt_r, err_cnt_nxt_s;
    logic          sync_n_r, sync_n_nxt_s;
    logic          cgs_done_r, cgs_done_nxt_s;
    logic          bad_s, is_k_s, resync_s;

    assign bad_s      = dec_valid & (dec_disp_err | dec_nit_err);
    assign is_k_s     = dec_valid & ~bad_s & dec_is_k & (dec_data == 8'hBC);
    assign kcnt_inc_s = kcnt_r + KW'(1);
    assign icnt_inc_s = icnt_r + IW'(1);

    // Next-state, run counters and saturating error counter
    always_comb begin
        state_nxt_s   = state_r;
        kcnt_nxt_s    = kcnt_r;
        icnt_nxt_s    = icnt_r;
        resync_s      = 1'b0;
        err_cnt_nxt_s = err_cnt_r;

        if (err_clr) begin
            err_cnt_nxt_s = bad_s ? 8'd1 : 8'd0;
        end else if (bad_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_nxt_s = err_cnt_r + 8'd1;
        end else begin
            err_cnt_nxt_s = err_cnt_r;
        end

        case (state_r)
            CS_INIT: begin
                if (dec_valid) begin
                    if (is_k_s) begin
                        if (kcnt_inc_s == K_LIM) begin
                            state_nxt_s = CS_CHECK;
                            kcnt_nxt_s  = '0;
                        end else begin
                            kcnt_nxt_s = kcnt_inc_s;
                        end
                    end else begin
                        kcnt_nxt_s = '0;
                    end
                end else begin
                    kcnt_nxt_s = kcnt_r;
                end
            end
            CS_CHECK, CS_DATA: begin
                if (dec_valid) begin
                    if (bad_s) begin
                        if (icnt_inc_s == I_LIM) begin
                            state_nxt_s = CS_INIT;
                            icnt_nxt_s  = '0;
                            kcnt_nxt_s  = '0;
                            resync_s    = 1'b1;
                        end else begin
                            icnt_nxt_s = icnt_inc_s;
                        end
                    end else begin
                        icnt_nxt_s = '0;
                        if ((state_r == CS_CHECK) && !is_k_s) begin
                            state_nxt_s = CS_DATA;
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end
                end else begin
                    icnt_nxt_s = icnt_r;
                end
            end
            default: begin
                state_nxt_s = CS_INIT;
                kcnt_nxt_s  = '0;
                icnt_nxt_s  = '0;
            end
        endcase
    end

`ifdef JESD_CGS_ERR_REPORT_EN
    logic [1:0] pcnt_r, pcnt_nxt_s;

    // Error-report pulse window: reloads on each non-fatal CS_DATA error, cleared by resync
    always_comb begin
        pcnt_nxt_s = pcnt_r;
        if (resync_s) begin
            pcnt_nxt_s = 2'd0;
        end else if ((state_r == CS_DATA) && bad_s) begin
            pcnt_nxt_s = 2'd2;
        end else if (pcnt_r != 2'd0) begin
            pcnt_nxt_s = pcnt_r - 2'd1;
        end else begin
            pcnt_nxt_s = 2'd0;
        end
        sync_n_nxt_s   = (state_nxt_s != CS_INIT) && (pcnt_nxt_s == 2'd0);
        cgs_done_nxt_s = (state_nxt_s == CS_DATA);
    end

    // Pulse window register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_r <= 2'd0;
        end else begin
            pcnt_r <= pcnt_nxt_s;
        end
    end
`else
    // Output decode from the next state so the outputs are registered alongside it
    always_comb begin
        sync_n_nxt_s   = (state_nxt_s != CS_INIT);
        cgs_done_nxt_s = (state_nxt_s == CS_DATA);
    end
`endif

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= CS_INIT;
            kcnt_r     <= '0;
            icnt_r     <= '0;
            err_cnt_r  <= 8'd0;
            sync_n_r   <= 1'b0;
            cgs_done_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            kcnt_r     <= kcnt_nxt_s;
            icnt_r     <= icnt_nxt_s;
            err_cnt_r  <= err_cnt_nxt_s;
            sync_n_r   <= sync_n_nxt_s;
            cgs_done_r <= cgs_done_nxt_s;
        end
    end

    assign cgs_state = state_r;
    assign sync_n    = sync_n_r;
    assign cgs_done  = cgs_done_r;
    assign err_cnt   = err_cnt_r;

endmodule
